mmio_timer_port: RTL

- Memory-mapped peripheral that acts as a responder on the CPU data bus (d_addr / d_bus / memory_read / memory_write), alongside the data memory.
- Decodes a small register window and provides:
  - an LED output register;
  - a prescaled 16-bit down-counter timer with an expiry flag and interrupt.
- The top level gates the bus: it ORs this block's read data onto d_bus when d_oe is high, and it masks the memory's output when this block's window is hit.

---
 rtl/mmio_pkg.sv | 35 +++
 rtl/mmio_prescaled_timer.sv | 50 +++++
 rtl/mmio_timer_port.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared bus widths and register map for the MMIO timer/LED port.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package mmio_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  // Register offsets inside the 8-word window
  localparam logic [2:0] REG_LED      = 3'd0;
  localparam logic [2:0] REG_CTRL     = 3'd1;
  localparam logic [2:0] REG_PRESCALE = 3'd2;
  localparam logic [2:0] REG_RELOAD   = 3'd3;
  localparam logic [2:0] REG_COUNT    = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;

  // CTRL and STATUS bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AR    = 1;
  localparam int CTRL_IE    = 2;
  localparam int STATUS_EXP = 0;

  // Field order puts en at bit 0 so the struct maps directly onto CTRL[2:0]
  typedef struct packed {
    logic ie;
    logic ar;
    logic en;
  } ctrl_t;

  // CTRL as seen on the bus: unused upper bits read as zero
  function automatic logic [DATA_W-1:0] ctrl_word(ctrl_t c);
    return {{(DATA_W-3){1'b0}}, c};
  endfunction

endpackage

// File: rtl/mmio_prescaled_timer.sv
// Prescaled 16-bit down-counter with expiry detection and optional auto-reload.
// Latency: count/pc update on the edge after a tick; expire is combinational on the tick cycle.
// Backpressure: none; a load request always overrides the tick update.
module mmio_prescaled_timer
  import mmio_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ar,
  input  logic [DATA_W-1:0] prescale,
  input  logic [DATA_W-1:0] reload,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] count,
  output logic              expire
);

  localparam logic [DATA_W-1:0] ONE = 1;

  logic [DATA_W-1:0] pc;
  logic              tick;

  // A tick fires when the prescaler counter reaches PRESCALE; a tick at zero is an expiry
  assign tick   = en && (pc == prescale);
  assign expire = tick && (count == '0);

  // Prescaler and counter; a RELOAD write beats any tick in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      count <= '0;
    end else if (load) begin
      count <= load_val;
      pc    <= '0;
    end else if (!en) begin
      pc <= '0;
    end else if (tick) begin
      pc <= '0;
      if (count != '0) begin
        count <= count - ONE;
      end else if (ar) begin
        count <= reload;
      end
    end else begin
      pc <= pc + ONE;
    end
  end

endmodule

// File: rtl/mmio_timer_port.sv
// Bus responder for an 8-word window: LED register plus a prescaled down-counter timer with IRQ.
// Latency: writes visible next cycle; reads return registered data with d_oe one cycle after the strobe.
// Backpressure: none; every in-window strobe is accepted, a read colliding with a write is dropped.
module mmio_timer_port
  import mmio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFF00,
  parameter logic [7:0]        RESET_LED = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memory_read,
  input  logic              memory_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_oe,
  output logic              hit,
  output logic [7:0]        led,
  output logic              irq
);

  // The window decode compares only the upper address bits, so the base must be 8-word aligned
  if (BASE_ADDR[2:0] != 3'd0) begin : g_base_check
    $error("mmio_timer_port: BASE_ADDR must be aligned to 8 words");
  end

  logic [2:0]        offset;
  logic              wr;
  logic              rd;
  ctrl_t             ctrl;
  logic [DATA_W-1:0] prescale;
  logic [DATA_W-1:0] reload;
  logic              exp_flag;
  logic [DATA_W-1:0] count;
  logic              expire;
  logic              load;
  logic [DATA_W-1:0] rdata_mux;

  assign hit    = (d_addr[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]);
  assign offset = d_addr[2:0];
  assign wr     = memory_write && hit;
  // A write in the same cycle takes priority and suppresses the read response
  assign rd     = memory_read && !memory_write && hit;
  assign load   = wr && (offset == REG_RELOAD);

  mmio_prescaled_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl.en),
    .ar       (ctrl.ar),
    .prescale (prescale),
    .reload   (reload),
    .load     (load),
    .load_val (d_wdata),
    .count    (count),
    .expire   (expire)
  );

  // Read-side view of the register map using pre-update register values
  always_comb begin
    rdata_mux = '0;
    case (offset)
      REG_LED:      rdata_mux = {{(DATA_W-8){1'b0}}, led};
      REG_CTRL:     rdata_mux = ctrl_word(ctrl);
      REG_PRESCALE: rdata_mux = prescale;
      REG_RELOAD:   rdata_mux = reload;
      REG_COUNT:    rdata_mux = count;
      REG_STATUS:   rdata_mux = {{(DATA_W-1){1'b0}}, exp_flag};
      default:      rdata_mux = '0;
    endcase
  end

  // Plain RW data registers: LED, PRESCALE, RELOAD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led      <= RESET_LED;
      prescale <= '0;
      reload   <= '0;
    end else if (wr) begin
      if (offset == REG_LED)      led      <= d_wdata[7:0];
      if (offset == REG_PRESCALE) prescale <= d_wdata;
      if (offset == REG_RELOAD)   reload   <= d_wdata;
    end
  end

  // CTRL: a bus write wins over the one-shot expiry clearing EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl <= '0;
    end else if (wr && (offset == REG_CTRL)) begin
      ctrl.en <= d_wdata[CTRL_EN];
      ctrl.ar <= d_wdata[CTRL_AR];
      ctrl.ie <= d_wdata[CTRL_IE];
    end else if (expire && !ctrl.ar) begin
      ctrl.en <= 1'b0;
    end
  end

  // EXP flag: set by expiry, cleared by writing 1; set wins when both happen together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_flag <= 1'b0;
    end else if (expire) begin
      exp_flag <= 1'b1;
    end else if (wr && (offset == REG_STATUS) && d_wdata[STATUS_EXP]) begin
      exp_flag <= 1'b0;
    end
  end

  // Registered interrupt level and one-cycle read response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq     <= 1'b0;
      d_oe    <= 1'b0;
      d_rdata <= '0;
    end else begin
      irq     <= exp_flag && ctrl.ie;
      d_oe    <= rd;
      d_rdata <= rd ? rdata_mux : '0;
    end
  end

endmodule
